uart_cmd_arbiter: RTL and testbench
===================================

// Module: uart_cmd_arbiter
// PURPOSE
//   Shares the single 8-bit command byte fed to uart_top.data_in between three requesters:
//   manual driving logic (req 0), barrier place/destroy logic (req 1) and auto-navigation (req 2).
//   Fixed-priority arbitration with a minimum grant hold, a stop-byte gap between owners and a one-shot barrier grant.
//   Sits between the driving FSMs and uart_top inside SimulatedDevice.
// PARAMETERS
//   HOLD_CYCLES   10_000_000  minimum cycles a grant is kept before preemption (100 ms @ 100 MHz)
//   GAP_CYCLES    1_000_000   cycles the stop byte is sent between two owners
//   PULSE_CYCLES  5_000_000   fixed length of a barrier grant, independent of req 1
//   MAX_GRANT     500_000_000 watchdog limit per grant (used only with ARB_WATCHDOG_EN)
// PORTS
//   sys_clk    in   1  100 MHz system clock
//   rst        in   1  asynchronous reset, active-high
//   req        in   3  request vector; bit 0 manual, bit 1 barrier, bit 2 auto
//   man_cmd    in   6  {destroy,place,right,left,back,fwd} from manual FSM
//   barr_cmd   in   2  {destroy,place}; bits [3:0] of payload forced 0 for this owner
//   auto_cmd   in   6  same layout as man_cmd
//   grant      out  3  one-hot grant, registered
//   cmd_out    out  8  byte to uart_top data_in: {2'b10, payload[5:0]}
//   busy       out  1  1 in any state except IDLE
//   wd_fault   out  1  sticky watchdog flag (0 when ARB_WATCHDOG_EN undefined)
// BEHAVIOUR
//   - States: IDLE, OWN, GAP. All outputs registered; counters sized $clog2(max param + 1).
//   - Reset (async, any time incl. mid-grant): state IDLE, grant 3'b000, cmd_out 8'h80, busy 0, wd_fault 0, counters 0.
//   - IDLE: if req != 0, grant lowest set index (0 > 1 > 2) -> OWN; grant and cmd_out valid next cycle (1-cycle latency).
//   - OWN: cmd_out = {2'b10, payload of owner} every cycle (payload tracks live *_cmd, one cycle late); hold counter counts up.
//   - OWN -> GAP on any of: owner req drops; higher-priority req set AND hold counter >= HOLD_CYCLES-1;
//     barrier owner after exactly PULSE_CYCLES grant cycles (regardless of req 1).
//   - Owner req drop releases immediately, even before HOLD_CYCLES; release beats preemption when simultaneous.
//   - GAP: grant 0, cmd_out 8'h80 (stop, no barrier action) for exactly GAP_CYCLES, then re-arbitrate directly
//     (GAP -> OWN if req != 0 else IDLE); no extra IDLE cycle.
//   - Barrier re-arm: req 1 is ignored after a barrier grant until it has been observed low for >= 1 cycle
//     (one barrier action per request pulse).
//   - Lower-priority req never preempts; equal priority impossible (one-hot owner).
//   - Owner request with payload 0 still owns the bus (sends 8'h80) — this is how manual stops auto.
// CONFIGURATION
//   ARB_WATCHDOG_EN defined: grant counter also compared to MAX_GRANT; on reaching it the owner is forced
//     to GAP, wd_fault sets and stays 1 until rst, and that owner's req is masked until it drops once.
//   ARB_WATCHDOG_EN undefined: no limit, no watchdog logic synthesised, wd_fault tied 0.
// TESTING  (bench params HOLD=4, GAP=2, PULSE=3, MAX_GRANT=20)
//   - req=3'b100, auto_cmd=6'b000001 -> next cycle grant=3'b100, cmd_out=8'h81, busy=1.
//   - auto owns 2 cycles, req[0] set with man_cmd=6'b000100 -> auto held until 4 grant cycles, 2 cycles 8'h80, then grant=3'b001, cmd_out=8'h84.
//   - req[1] held high, barr_cmd=2'b01 -> cmd_out=8'h90 for exactly 3 cycles, GAP, no re-grant until req[1] toggles low/high.
//   - manual owner drops req at grant cycle 1 with req[2] high -> immediate GAP (2 cycles 8'h80) then auto granted.
//   - rst pulsed mid-OWN -> same cycle grant=0, cmd_out=8'h80, busy=0; resumes arbitration after rst low.
//   - ARB_WATCHDOG_EN: req[2] held 30 cycles -> forced release at grant cycle 20, wd_fault=1 until rst.

Source files
------------

// File: rtl/uart_cmd_arbiter.sv
// uart_cmd_arbiter
//   Shares the single command byte sent to uart_top.data_in between three
//   requesters: manual driving (req[0]), barrier place/destroy (req[1]) and
//   auto-navigation (req[2]). Arbitration uses fixed priority (0 > 1 > 2).
//   A granted owner cannot be preempted until it has held the bus for
//   HOLD_CYCLES cycles. A stop byte is sent for GAP_CYCLES cycles between
//   two owners. A barrier grant lasts exactly PULSE_CYCLES cycles, and each
//   req[1] pulse produces only one barrier grant.
//
//   Optional feature macro: ARB_WATCHDOG_EN
//     When defined, a grant is forcibly ended after MAX_GRANT cycles.
//     wd_fault then latches high, and the offending requester is masked
//     until its req drops. When undefined, wd_fault is tied low.
//
// Ports
//   sys_clk   in   1  system clock
//   rst       in   1  asynchronous reset, active-high
//   req       in   3  requests: [0] manual, [1] barrier, [2] auto
//   man_cmd   in   6  {destroy,place,right,left,back,fwd} from manual FSM
//   barr_cmd  in   2  {destroy,place}; low four payload bits forced 0
//   auto_cmd  in   6  same layout as man_cmd
//   grant     out  3  one-hot grant (registered)
//   cmd_out   out  8  {2'b10, payload} to uart_top data_in (registered)
//   busy      out  1  high whenever not idle (registered)
//   wd_fault  out  1  sticky watchdog flag
module uart_cmd_arbiter #(
  parameter int unsigned HOLD_CYCLES  = 10_000_000,
  parameter int unsigned GAP_CYCLES   = 1_000_000,
  parameter int unsigned PULSE_CYCLES = 5_000_000,
  parameter int unsigned MAX_GRANT    = 500_000_000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [5:0] man_cmd,
  input  logic [1:0] barr_cmd,
  input  logic [5:0] auto_cmd,
  output logic [2:0] grant,
  output logic [7:0] cmd_out,
  output logic       busy,
  output logic       wd_fault
);

  localparam int unsigned MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_HGP = (MAX_HG > PULSE_CYCLES) ? MAX_HG : PULSE_CYCLES;
  localparam int unsigned CNT_TOP = (MAX_HGP > MAX_GRANT) ? MAX_HGP : MAX_GRANT;
  localparam int unsigned CW      = $clog2(CNT_TOP + 1);

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT    = CW'(CNT_TOP);
  localparam logic [7:0]    STOP_BYTE  = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic [7:0]    cmd_q, cmd_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;

  logic [2:0]    eff;
  logic [2:0]    win;
  logic          drop_rel;
  logic          pulse_done;
  logic          preempt;
  logic          leave;
  logic          rearb;

`ifdef ARB_WATCHDOG_EN
  localparam logic [CW-1:0] WD_LAST = CW'(MAX_GRANT - 1);
  logic          wd_q, wd_d;
  logic [2:0]    mask_q, mask_d;
  logic          wd_hit;
`endif

  function automatic logic [2:0] first_set(input logic [2:0] r);
    logic [2:0] g;
    g = 3'b000;
    if (r[0])      g = 3'b001;
    else if (r[1]) g = 3'b010;
    else if (r[2]) g = 3'b100;
    return g;
  endfunction

  function automatic logic [5:0] payload_of(input logic [2:0] g,
                                            input logic [5:0] m,
                                            input logic [1:0] b,
                                            input logic [5:0] a);
    logic [5:0] p;
    p = '0;
    case (g)
      3'b001:  p = m;
      3'b010:  p = {b, 4'b0000};
      3'b100:  p = a;
      default: p = '0;
    endcase
    return p;
  endfunction

  // Effective requests: req[1] needs re-arming after each barrier grant, and
  // a watchdog-released owner stays masked until its req drops.
`ifdef ARB_WATCHDOG_EN
  assign eff = req & {1'b1, armed_q, 1'b1} & ~mask_q;
  assign wd_hit = (state_q == ST_OWN) && (cnt_q == WD_LAST);
`else
  assign eff = req & {1'b1, armed_q, 1'b1};
`endif

  assign win = first_set(eff);

  // The barrier grant has a fixed length, so only manual and auto owners
  // release the bus early when their req drops.
  assign drop_rel   = |(grant_q & ~req & 3'b101);
  assign pulse_done = grant_q[1] && (cnt_q == PULSE_LAST);
  // For a one-hot grant, grant-1 selects exactly the higher-priority bits.
  assign preempt    = |(eff & (grant_q - 3'd1)) && (cnt_q >= HOLD_LAST);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    armed_d = armed_q | ~req[1];
    rearb   = 1'b0;
    leave   = 1'b0;
`ifdef ARB_WATCHDOG_EN
    wd_d    = wd_q;
    mask_d  = mask_q & req;
`endif

    case (state_q)
      ST_IDLE: rearb = 1'b1;

      ST_OWN: begin
        leave = drop_rel | pulse_done | preempt;
`ifdef ARB_WATCHDOG_EN
        if (wd_hit) begin
          leave  = 1'b1;
          wd_d   = 1'b1;
          mask_d = mask_d | grant_q;
        end
`endif
        if (leave) begin
          state_d = ST_GAP;
          grant_d = '0;
          cmd_d   = STOP_BYTE;
          cnt_d   = '0;
        end else begin
          cmd_d = {2'b10, payload_of(grant_q, man_cmd, barr_cmd, auto_cmd)};
          cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) rearb = 1'b1;
        else                   cnt_d = cnt_q + 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cmd_d   = STOP_BYTE;
        cnt_d   = '0;
      end
    endcase

    // Arbitration is shared by IDLE and the last GAP cycle, so a gap flows
    // straight into the next owner without an intermediate idle cycle.
    if (rearb) begin
      cnt_d = '0;
      if (|win) begin
        state_d = ST_OWN;
        grant_d = win;
        cmd_d   = {2'b10, payload_of(win, man_cmd, barr_cmd, auto_cmd)};
        if (win[1]) armed_d = 1'b0;
      end else begin
        state_d = ST_IDLE;
        grant_d = '0;
        cmd_d   = STOP_BYTE;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      cmd_q   <= STOP_BYTE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cmd_q   <= cmd_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

`ifdef ARB_WATCHDOG_EN
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wd_q   <= 1'b0;
      mask_q <= '0;
    end else begin
      wd_q   <= wd_d;
      mask_q <= mask_d;
    end
  end

  assign wd_fault = wd_q;
`else
  assign wd_fault = 1'b0;
`endif

  assign grant   = grant_q;
  assign cmd_out = cmd_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_cmd_arbiter.sv
// Testbench for uart_cmd_arbiter. Stimulus is driven one cycle at a time.
// After each clock edge, a behavioural model (owner / visible-cycle
// bookkeeping) computes the expected outputs and pushes them into a queue.
// A monitor pops each entry on the falling edge and compares it with the DUT.
module tb_uart_cmd_arbiter;

  localparam int unsigned T_HOLD  = 4;
  localparam int unsigned T_GAP   = 2;
  localparam int unsigned T_PULSE = 3;
  localparam int unsigned T_MAXG  = 20;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic [5:0] man_cmd;
  logic [1:0] barr_cmd;
  logic [5:0] auto_cmd;
  logic [2:0] grant;
  logic [7:0] cmd_out;
  logic       busy;
  logic       wd_fault;

  always #5 sys_clk = ~sys_clk;

  uart_cmd_arbiter #(
    .HOLD_CYCLES (T_HOLD),
    .GAP_CYCLES  (T_GAP),
    .PULSE_CYCLES(T_PULSE),
    .MAX_GRANT   (T_MAXG)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .req     (req),
    .man_cmd (man_cmd),
    .barr_cmd(barr_cmd),
    .auto_cmd(auto_cmd),
    .grant   (grant),
    .cmd_out (cmd_out),
    .busy    (busy),
    .wd_fault(wd_fault)
  );

  typedef struct packed {
    logic [2:0] g;
    logic [7:0] c;
    logic       b;
    logic       w;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: who is shown on the bus and for how many cycles.
  int   owner;        // -1 when nobody holds the bus
  int   shown;        // cycles the current grant or gap has been visible
  bit   in_gap;
  bit   barr_spent;   // req[1] must be seen low before another barrier grant
  bit   wd_flag;
  bit [2:0] wd_mask;

  task automatic model_reset();
    owner      = -1;
    shown      = 0;
    in_gap     = 1'b0;
    barr_spent = 1'b0;
    wd_flag    = 1'b0;
    wd_mask    = '0;
  endtask

  function automatic bit eligible(int j, logic [2:0] r);
    return r[j] && !(j == 1 && barr_spent) && !wd_mask[j];
  endfunction

  task automatic model_step(input logic [2:0] r);
    bit       leave;
    bit [2:0] keep_mask;
    int       pick;
    keep_mask = wd_mask & r;
    if (owner >= 0) begin
      leave = 1'b0;
      if (owner != 1 && !r[owner])            leave = 1'b1;
      if (owner == 1 && shown == int'(T_PULSE)) leave = 1'b1;
      if (shown >= int'(T_HOLD))
        for (int j = 0; j < owner; j++)
          if (eligible(j, r)) leave = 1'b1;
`ifdef ARB_WATCHDOG_EN
      if (shown == int'(T_MAXG)) begin
        leave = 1'b1;
        wd_flag = 1'b1;
        keep_mask[owner] = 1'b1;
      end
`endif
      if (leave) begin
        owner  = -1;
        in_gap = 1'b1;
        shown  = 1;
      end else begin
        shown++;
      end
    end else if (in_gap && shown < int'(T_GAP)) begin
      shown++;
    end else begin
      pick = -1;
      for (int j = 2; j >= 0; j--)
        if (eligible(j, r)) pick = j;
      in_gap = 1'b0;
      owner  = pick;
      shown  = 1;
      if (pick == 1) barr_spent = 1'b1;
    end
    if (!r[1]) barr_spent = 1'b0;
    wd_mask = keep_mask;
  endtask

  task automatic push_expect();
    exp_t e;
    logic [5:0] p;
    case (owner)
      0:       p = man_cmd;
      1:       p = {barr_cmd, 4'b0000};
      2:       p = auto_cmd;
      default: p = 6'd0;
    endcase
    e.g = (owner >= 0) ? 3'(1 << owner) : 3'b000;
    e.c = 8'h80 | {2'b00, p};
    e.b = (owner >= 0) || in_gap;
    e.w = wd_flag;
    sb.push_back(e);
  endtask

  // One clock: model the edge that just happened using the inputs it sampled.
  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (rst) model_reset();
    else     model_step(req);
    push_expect();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(logic [2:0] r, logic [5:0] m, logic [1:0] b, logic [5:0] a);
    req = r; man_cmd = m; barr_cmd = b; auto_cmd = a;
  endtask

  // Asynchronous reset asserted mid-cycle: outputs must clear in the same cycle.
  task automatic tick_reset();
    @(posedge sys_clk);
    #1;
    model_reset();
    push_expect();
    #1 rst = 1'b1;
  endtask

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("grant",    {5'd0, grant},    {5'd0, e.g});
      chk("cmd_out",  cmd_out,          e.c);
      chk("busy",     {7'd0, busy},     {7'd0, e.b});
      chk("wd_fault", {7'd0, wd_fault}, {7'd0, e.w});
    end
  end

  initial begin
    logic [2:0] r;
    model_reset();
    rst = 1'b1;
    drive(3'b000, 6'd0, 2'd0, 6'd0);
    run(2);
    rst = 1'b0;
    run(2);

    // Auto granted, then manual arrives and waits out the hold time.
    drive(3'b100, 6'd0, 2'd0, 6'b000001);
    run(2);
    drive(3'b101, 6'b000100, 2'd0, 6'b000001);
    run(10);
    drive(3'b000, 6'd0, 2'd0, 6'd0);
    run(4);

    // Barrier held high: one fixed-length grant, then re-arm by toggling.
    drive(3'b010, 6'd0, 2'b01, 6'd0);
    run(10);
    drive(3'b000, 6'd0, 2'b01, 6'd0);
    run(1);
    drive(3'b010, 6'd0, 2'b10, 6'd0);
    run(8);
    drive(3'b000, 6'd0, 2'd0, 6'd0);
    run(3);

    // Manual releases on its first grant cycle while auto waits.
    drive(3'b101, 6'b000010, 2'd0, 6'b001000);
    run(1);
    drive(3'b100, 6'b000010, 2'd0, 6'b001000);
    run(8);

    // Zero payload owner still holds the bus.
    drive(3'b101, 6'd0, 2'd0, 6'b111111);
    run(8);

    // Reset pulsed mid-grant, then arbitration resumes.
    drive(3'b100, 6'd0, 2'd0, 6'b000011);
    run(3);
    tick_reset();
    tick();
    rst = 1'b0;
    run(4);

    // Long auto hold (exercises the watchdog when enabled).
    drive(3'b100, 6'd0, 2'd0, 6'b010101);
    run(30);
    drive(3'b000, 6'd0, 2'd0, 6'd0);
    run(4);

    // Randomised traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      r = req;
      for (int b = 0; b < 3; b++)
        if ($urandom_range(5) == 0) r[b] = ~r[b];
      drive(r,
            ($urandom_range(3) == 0) ? 6'd0 : 6'($urandom),
            2'($urandom),
            ($urandom_range(3) == 0) ? 6'd0 : 6'($urandom));
      if ($urandom_range(199) == 0) begin
        tick_reset();
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    @(negedge sys_clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
